writeback_unit: RTL

Parametrised writeback stage for the RV32I pipeline. It selects the result source and performs load byte/halfword extraction with sign or zero extension. It registers the register-file write (one cycle, as the current stage does) and keeps a short history of committed writes, which decode can query combinationally for bypass. It also flags misaligned loads and counts retired instructions.

---
 rtl/writeback_unit_pkg.sv | 19 +
 rtl/writeback_unit_if.sv | 28 ++
 rtl/result_mux4.sv | 21 ++
 rtl/writeback_unit_load_align.sv | 43 ++++
 rtl/writeback_unit.sv | 109 ++++++++++
 5 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared encodings for the RV32I writeback stage: result source select and load funct3.
package writeback_unit_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_PC4  = 2'd2,
        SRC_IMM  = 2'd3
    } result_src_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

endpackage

// File: rtl/writeback_unit_if.sv
// W-stage instruction bundle handed from the previous pipeline stage to writeback.
interface writeback_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              valid_w;
    logic              stall_w;
    logic              flush_w;
    logic [1:0]        result_src_w;
    logic [2:0]        funct3_w;
    logic [1:0]        addr_lo_w;
    logic [XLEN-1:0]   alu_result_w;
    logic [XLEN-1:0]   read_data_w;
    logic [XLEN-1:0]   pc_plus4_w;
    logic [XLEN-1:0]   imm_w;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_w;

    modport master (
        output valid_w, stall_w, flush_w, result_src_w, funct3_w, addr_lo_w,
               alu_result_w, read_data_w, pc_plus4_w, imm_w, rd_w, reg_write_w
    );

    modport slave (
        input  valid_w, stall_w, flush_w, result_src_w, funct3_w, addr_lo_w,
               alu_result_w, read_data_w, pc_plus4_w, imm_w, rd_w, reg_write_w
    );
endinterface

// File: rtl/result_mux4.sv
// Generic 4:1 result-source multiplexer shared across pipeline stages.
module result_mux4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] out
);
    // Select one of four sources.
    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end
endmodule

// File: rtl/writeback_unit_load_align.sv
// Load lane extraction, sign/zero extension and misaligned/illegal load detection.
module load_align
    import writeback_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_load,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        illegal;

    // Pick the addressed lane, extend it, and classify the access.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        load_data = read_data;
        illegal   = 1'b0;
        byte_lane = read_data[7:0];
        case (addr_lo)
            2'd0:    byte_lane = read_data[7:0];
            2'd1:    byte_lane = read_data[15:8];
            2'd2:    byte_lane = read_data[23:16];
            default: byte_lane = read_data[31:24];
        endcase
        half_lane = addr_lo[1] ? read_data[31:16] : read_data[15:0];
        case (funct3)
            F3_LB:   load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LH:   load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LW:   load_data = read_data;
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_lane};
            default: illegal   = 1'b1;
        endcase
        misalign = is_load && (illegal
                   || (((funct3 == F3_LH) || (funct3 == F3_LHU)) && addr_lo[0])
                   || ((funct3 == F3_LW) && (addr_lo != 2'd0)));
    end
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: result select, registered register-file write, commit history for bypass, retire counter.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int HIST_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    writeback_unit_if.slave   w,
    input  logic [REG_AW-1:0] rs1_q,
    input  logic [REG_AW-1:0] rs2_q,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              rs1_hit,
    output logic              rs2_hit,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              load_misalign,
    output logic [CNT_W-1:0]  retired
);
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } hist_entry_t;

    hist_entry_t     hist [HIST_DEPTH];
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;
    logic            misalign;
    logic            accept;
    logic            commit;

    load_align #(.XLEN(XLEN)) u_load_align (
        .is_load   (w.result_src_w == SRC_LOAD),
        .funct3    (w.funct3_w),
        .addr_lo   (w.addr_lo_w),
        .read_data (w.read_data_w),
        .load_data (load_data),
        .misalign  (misalign)
    );

    result_mux4 #(.W(XLEN)) u_result_mux (
        .sel (w.result_src_w),
        .in0 (w.alu_result_w),
        .in1 (load_data),
        .in2 (w.pc_plus4_w),
        .in3 (w.imm_w),
        .out (result)
    );

    // Flush beats stall; a misaligned load retires but never writes.
    always_comb begin
        accept = w.valid_w && !w.stall_w && !w.flush_w;
        commit = accept && w.reg_write_w && (w.rd_w != '0) && !misalign;
    end

    // Register the write, shift history on commit, count retirements.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            load_misalign <= 1'b0;
            retired       <= '0;
            // NOTE: history is a handful of flops read for bypass, so clearing it on reset is cheap and keeps stale entries from hitting.
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so the shift below reads pre-edge values.
            rf_we         <= commit;
            load_misalign <= accept && misalign;
            if (accept) begin
                retired <= retired + CNT_W'(1);
            end
            if (commit) begin
                rf_waddr <= w.rd_w;
                rf_wdata <= result;
                for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                    hist[k] <= hist[k-1];
                end
                hist[0] <= '{valid: 1'b1, addr: w.rd_w, data: result};
            end
        end
    end

    // Bypass lookup: scan oldest to newest so the newest match overrides.
    always_comb begin
        rs1_hit  = 1'b0;
        rs2_hit  = 1'b0;
        rs1_data = '0;
        rs2_data = '0;
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (hist[k].valid && (hist[k].addr == rs1_q) && (rs1_q != '0)) begin
                rs1_hit  = 1'b1;
                rs1_data = hist[k].data;
            end
            if (hist[k].valid && (hist[k].addr == rs2_q) && (rs2_q != '0)) begin
                rs2_hit  = 1'b1;
                rs2_data = hist[k].data;
            end
        end
    end
endmodule
